// File: rtl/mem_if_pkg.sv
// Shared types and constants for the store buffer sitting in front of the Memory port.
package mem_if_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WORD_OFS   = 2;

    typedef enum logic {
        SB_RUN,
        SB_FLUSH
    } sb_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Combinational search for the youngest buffered store whose word address matches a load.
module sb_match #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 30,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
    input  logic [PTR_W-1:0]            head_i,
    input  logic [CNT_W-1:0]            count_i,
    input  logic [TAG_W-1:0]            key_i,
    output logic                        hit_o,
    output logic [PTR_W-1:0]            idx_o
);

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        // Walk from head towards tail so the last match kept is the youngest store.
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_i) && (tags_i[head_i + PTR_W'(i)] == key_i)) begin
                hit_o = 1'b1;
                idx_o = head_i + PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between the CPU MEM stage and Memory; owns the single Memory port.
// Load forwarding from queued stores is built only when STORE_BUF_FWD_EN is defined.
module store_buffer
    import mem_if_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              flush,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << WORD_OFS) - 1);

    sb_state_t          state_q, state_d;
    sb_entry_t          entries_q [DEPTH];
    sb_entry_t          headEntry;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  alignedAddr;
    logic               full, loadReady, storeAccept, loadAccept, loadMiss, drain;

    assign alignedAddr = cpu_addr & WORD_MASK;
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign headEntry   = entries_q[head_q];
    assign cpu_rvalid  = rvalid_q;
    assign cpu_rdata   = rdata_q;

`ifdef STORE_BUF_FWD_EN
    logic [DEPTH-1:0][ADDR_W-WORD_OFS-1:0] tags;
    logic                                  loadHit;
    logic [PTR_W-1:0]                      hitIdx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tags[i] = entries_q[i].addr[ADDR_W-1:WORD_OFS];
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .TAG_W (ADDR_W - WORD_OFS)
    ) u_match (
        .tags_i  (tags),
        .head_i  (head_q),
        .count_i (count_q),
        .key_i   (alignedAddr[ADDR_W-1:WORD_OFS]),
        .hit_o   (loadHit),
        .idx_o   (hitIdx)
    );

    assign loadReady = 1'b1;
    assign loadMiss  = loadAccept & ~loadHit;
`else
    // Without forwarding a load must wait until every older store is in Memory.
    assign loadReady = empty;
    assign loadMiss  = loadAccept;
`endif

    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        unique case (state_q)
            SB_RUN: begin
                cpu_ready = cpu_we ? ~full : loadReady;
                if (flush) state_d = SB_FLUSH;
            end
            SB_FLUSH: begin
                if (empty && !flush) state_d = SB_RUN;
            end
            default: state_d = SB_RUN;
        endcase
    end

    assign storeAccept = cpu_valid & cpu_ready & cpu_we;
    assign loadAccept  = cpu_valid & cpu_ready & ~cpu_we;
    assign drain       = ~loadMiss & ~empty;

    // A load miss owns the port; otherwise the oldest store drains.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        if (loadMiss) begin
            mem_read    = 1'b1;
            mem_address = alignedAddr;
        end else if (drain) begin
            mem_write   = 1'b1;
            mem_address = headEntry.addr[ADDR_W-1:0];
            mem_wdata   = headEntry.data[DATA_W-1:0];
        end
    end

    always_comb begin
        head_d  = drain ? head_q + PTR_W'(1) : head_q;
        tail_d  = storeAccept ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (storeAccept && !drain) count_d = count_q + CNT_W'(1);
        if (!storeAccept && drain) count_d = count_q - CNT_W'(1);
        rdata_d = rdata_q;
        if (loadAccept) begin
`ifdef STORE_BUF_FWD_EN
            rdata_d = loadHit ? entries_q[hitIdx].data[DATA_W-1:0] : mem_rdata;
`else
            rdata_d = mem_rdata;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SB_RUN;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rvalid_q <= loadAccept;
            rdata_q  <= rdata_d;
        end
    end

    // Entry storage needs no reset: count/pointers define which slots are live.
    always_ff @(posedge clock) begin
        if (storeAccept) begin
            entries_q[tail_q] <= '{addr: ADDR_W_DEF'(alignedAddr), data: DATA_W_DEF'(cpu_wdata)};
        end
    end

endmodule
